// File: rtl/mor1kx_dpram_be_sclk.sv
// Single-clock simple dual-port RAM with per-byte write enables,
// byte-merging read-during-write bypass and optional output register.
module mor1kx_dpram_be_sclk #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int CLEAR_ON_INIT = 0,
    parameter int ENABLE_BYPASS = 1,
    parameter int OUTPUT_REG    = 0,
    localparam int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit BYP   = (ENABLE_BYPASS != 0);
    localparam logic [DATA_WIDTH-1:0] INIT_WORD =
        (CLEAR_ON_INIT != 0) ? '0 : 'x;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] din_r;
    logic [NUM_BYTES-1:0]  mask;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  v1;

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i])
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH]
                        <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Bypass captures the write lanes so the merge happens after the RAM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
            din_r <= '0;
            mask  <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= re;
            if (re) begin
                rdata <= mem[raddr];
                if (BYP && we && (raddr == waddr)) begin
                    din_r <= din;
                    mask  <= be;
                end else begin
                    mask  <= '0;
                end
            end
        end
    end

    always_comb begin
        s1_data = rdata;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mask[i])
                s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    din_r[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  v2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_data <= '0;
                v2      <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1)
                    s2_data <= s1_data;
            end
        end

        assign dout       = s2_data;
        assign dout_valid = v2;
    end else begin : g_noreg
        assign dout       = s1_data;
        assign dout_valid = v1;
    end

endmodule

// File: tb/tb_mor1kx_dpram_be_sclk.sv
// Directed bench: three DUT flavours share one stimulus stream
// (latency 1 with bypass, latency 1 without bypass, latency 2).
module tb_mor1kx_dpram_be_sclk;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] raddr;
    logic          re;
    logic [AW-1:0] waddr;
    logic          we;
    logic [NB-1:0] be;
    logic [DW-1:0] din;

    logic [DW-1:0] dout0, dout1, dout2;
    logic          dv0, dv1, dv2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mor1kx_dpram_be_sclk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .CLEAR_ON_INIT(1), .ENABLE_BYPASS(1), .OUTPUT_REG(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re),
        .waddr(waddr), .we(we), .be(be), .din(din),
        .dout(dout0), .dout_valid(dv0)
    );

    mor1kx_dpram_be_sclk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .CLEAR_ON_INIT(1), .ENABLE_BYPASS(0), .OUTPUT_REG(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re),
        .waddr(waddr), .we(we), .be(be), .din(din),
        .dout(dout1), .dout_valid(dv1)
    );

    mor1kx_dpram_be_sclk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .CLEAR_ON_INIT(1), .ENABLE_BYPASS(1), .OUTPUT_REG(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re),
        .waddr(waddr), .we(we), .be(be), .din(din),
        .dout(dout2), .dout_valid(dv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] b);
        we = 1'b1; waddr = a; din = d; be = b;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; be = '0; din = '0;
        tick();
        tick();
        chk("init_dout0", dout0, 32'h0);
        chk("init_dv0", {31'b0, dv0}, 32'h0);
        chk("init_dout2", dout2, 32'h0);

        rst_n = 1'b1;
        wr(4'd9, 32'h55667788, 4'hF);

        // reset with re/we active: nothing written, nothing read
        rst_n = 1'b0;
        re = 1'b1; raddr = 4'd9;
        we = 1'b1; waddr = 4'd9; be = 4'hF; din = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_dout0", dout0, 32'h0);
            chk("rst_dv0", {31'b0, dv0}, 32'h0);
            chk("rst_dout2", dout2, 32'h0);
            chk("rst_dv2", {31'b0, dv2}, 32'h0);
        end
        rst_n = 1'b1; we = 1'b0; be = '0;
        tick();
        chk("post_rst_rd", dout0, 32'h55667788);
        chk("post_rst_dv0", {31'b0, dv0}, 32'h1);
        re = 1'b0;
        tick();
        chk("post_rst_dv0_low", {31'b0, dv0}, 32'h0);
        chk("post_rst_rd2", dout2, 32'h55667788);
        chk("post_rst_dv2", {31'b0, dv2}, 32'h1);

        // full word write then read
        wr(4'd5, 32'hDEADBEEF, 4'hF);
        re = 1'b1; raddr = 4'd5;
        tick();
        chk("full_rd", dout0, 32'hDEADBEEF);
        chk("full_dv", {31'b0, dv0}, 32'h1);
        re = 1'b0;
        tick();
        chk("full_dv_low", {31'b0, dv0}, 32'h0);
        chk("full_hold", dout0, 32'hDEADBEEF);

        // partial byte write
        wr(4'd7, 32'h11223344, 4'hF);
        wr(4'd7, 32'hAABBCCDD, 4'b0101);
        re = 1'b1; raddr = 4'd7;
        tick();
        re = 1'b0;
        chk("be_rd", dout0, 32'h11BB33DD);

        // same-address read during write
        wr(4'd3, 32'h01020304, 4'hF);
        re = 1'b1; raddr = 4'd3;
        we = 1'b1; waddr = 4'd3; din = 32'hF0F1F2F3; be = 4'b1001;
        tick();
        re = 1'b0; we = 1'b0;
        chk("byp_merge", dout0, 32'hF00203F3);
        chk("nobyp_old", dout1, 32'h01020304);
        tick();
        chk("byp_merge_l2", dout2, 32'hF00203F3);
        chk("byp_hold", dout0, 32'hF00203F3);
        re = 1'b1; raddr = 4'd3;
        tick();
        re = 1'b0;
        chk("byp_mem", dout1, 32'hF00203F3);

        // latency-2 back-to-back reads
        wr(4'd0, 32'hA, 4'hF);
        wr(4'd1, 32'hB, 4'hF);
        wr(4'd2, 32'hC, 4'hF);
        re = 1'b1; raddr = 4'd0;
        tick();
        chk("pipe_dv_c1", {31'b0, dv2}, 32'h0);
        raddr = 4'd1;
        tick();
        chk("pipe_a", dout2, 32'hA);
        chk("pipe_a_dv", {31'b0, dv2}, 32'h1);
        raddr = 4'd2;
        tick();
        chk("pipe_b", dout2, 32'hB);
        chk("pipe_b_dv", {31'b0, dv2}, 32'h1);
        re = 1'b0;
        tick();
        chk("pipe_c", dout2, 32'hC);
        chk("pipe_c_dv", {31'b0, dv2}, 32'h1);
        wr(4'd2, 32'hDD, 4'hF);
        chk("pipe_hold", dout2, 32'hC);
        chk("pipe_dv_low", {31'b0, dv2}, 32'h0);
        tick();
        chk("pipe_hold2", dout2, 32'hC);
        chk("l1_hold", dout0, 32'hC);

        // reset while a latency-2 read is in flight
        re = 1'b1; raddr = 4'd1;
        tick();
        re = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_dv", {31'b0, dv2}, 32'h0);
        chk("mid_rst_dout", dout2, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_dv2", {31'b0, dv2}, 32'h0);
        chk("mid_rst_dout2", dout2, 32'h0);
        tick();
        chk("mid_rst_dv3", {31'b0, dv2}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mor1kx_dpram_be_sclk.md
Name: mor1kx_dpram_be_sclk

Overview:
Single-clock simple dual-port RAM (one read port, one write port) with per-byte write enables. Same-address read-during-write bypass merges per byte. Optional output pipeline register and a read-valid strobe. Successor to the team's plain simple DPRAM, intended for cache data/tag arrays and store buffers that need partial-word writes and a registered output for timing.

Parameters:
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH (elaboration error otherwise)
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
CLEAR_ON_INIT, 0, 1 = memory initialised to all-zero at simulation/bitstream init
ENABLE_BYPASS, 1, 1 = same-address read-during-write returns newly written bytes; 0 = returns old data
OUTPUT_REG, 0, 1 = add a second output register stage (read latency 2 instead of 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
raddr  in  ADDR_WIDTH  read address
re  in  1  read enable
waddr  in  ADDR_WIDTH  write address
we  in  1  write enable
be  in  NUM_BYTES  per-lane write enable; lane i = din[i*BYTE_WIDTH +: BYTE_WIDTH]
din  in  DATA_WIDTH  write data
dout  out  DATA_WIDTH  read data
dout_valid  out  1  one-cycle strobe: dout holds data for a read accepted L cycles earlier

Behaviour:
- Reset is synchronous and active-low. The clock is clk and the reset is rst_n.
- Read latency L = 1 + OUTPUT_REG.
- Reset (rst_n=0 at a clk edge) clears the following to 0: stage-1 data, bypass lane mask, stage-2 data and the valid pipeline. Consequently dout=0 and dout_valid=0.
- Memory contents are not reset. While rst_n=0, re and we are ignored and no memory lane is written. Reads in flight at reset are dropped and their valid strobe is never issued.
- Write: at an edge with we=1, each lane i with be[i]=1 stores din lane i at waddr. Lanes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
- Read stage 1: at an edge with re=1, rdata <= mem[raddr] (pre-write contents).
- Bypass with ENABLE_BYPASS=1: at an edge with re & we & (raddr==waddr), capture din_r <= din and mask <= be. Any other edge with re=1 sets mask <= 0.
- Stage-1 output: lane i = mask[i] ? din_r lane i : rdata lane i. The result is the per-byte merge of old and new data.
- With ENABLE_BYPASS=0 there is no bypass logic. A same-address read returns the old word.
- re=0: stage-1 data and mask hold. The stage-1 output is stable.
- Stage 2 (OUTPUT_REG=1): loads the stage-1 output at the edge after a stage-1 read (re delayed by one cycle), otherwise holds. dout = stage 2. With OUTPUT_REG=0, dout = stage-1 output.
- dout changes only in the cycle L after an accepted read (or on reset). It never changes because of a write alone, including a write to the address last read.
- dout_valid: re shifted through L registers (gated by rst_n). Back-to-back reads give back-to-back valid strobes with full throughput, one read per cycle.
- Address wrap: addresses are ADDR_WIDTH bits. There is no out-of-range case.
- Simultaneous read and write to different addresses are independent. The read returns the old contents at raddr.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with re=1, we=1, be=all ones -> dout=0 and dout_valid=0 throughout. After release, a read of that address returns the prior contents (no write occurred).
- Full write/read, OUTPUT_REG=0: write 0xDEADBEEF to addr 5 with be=4'b1111, then re addr 5 -> next cycle dout=0xDEADBEEF and dout_valid=1 for exactly one cycle.
- Byte-enable: addr 7 holds 0x11223344; write din=0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
- Bypass merge: addr 3 holds 0x01020304; same cycle re+we addr 3, din=0xF0F1F2F3, be=4'b1001 -> next cycle dout=0xF00203F3. With ENABLE_BYPASS=0 the same stimulus gives 0x01020304.
- OUTPUT_REG=1 pipeline: reads of addr 0,1,2 on consecutive cycles (contents 0xA,0xB,0xC) -> dout=0xA,0xB,0xC with dout_valid=1 on cycles 2,3,4. With re=0 afterwards, dout holds 0xC even if addr 2 is rewritten.
- Reset mid-read (OUTPUT_REG=1): issue read, assert rst_n=0 the following cycle -> no dout_valid pulse, and dout=0.
